// File: rtl/tdm_pkg.sv
// tdm_pkg: shared states, slot codes and miss-counter width for the TDM demux
package tdm_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;
  localparam int MISS_W = 4;
endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr: 2-bit slot counter with clear, load-to-1 and increment
module tdm_slot_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic       en,
  output logic [1:0] slot
);
  logic [1:0] slot_d, slot_q;
  always_comb slot_d = clr ? 2'd0 : load ? 2'd1 : en ? slot_q + 2'd1 : slot_q;
  always_ff @(posedge clk) slot_q <= rst ? 2'd0 : slot_d;
  assign slot = slot_q;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: four-slot TDM demultiplexer with frame lock tracking
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = 1,
  parameter int MISS_MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] C,
  output logic [W-1:0] D,
  output logic         frame_valid,
  output logic [1:0]   slot,
  output logic         locked,
  output logic         sync_err
);
  localparam logic [MISS_W-1:0] MISS_LIM = MISS_W'(MISS_MAX);
  state_t state_d, state_q;
  logic [MISS_W-1:0] miss_d, miss_q;
  logic [W-1:0] shadow_d [3];
  logic [W-1:0] shadow_q [3];
  logic [W-1:0] a_d, b_d, c_d, d_d, a_q, b_q, c_q, d_q;
  logic fv_d, fv_q, se_d, se_q;
  logic clr, load, en;
  tdm_slot_ctr u_slot (.clk(clk), .rst(rst), .clr(clr), .load(load), .en(en), .slot(slot));
  always_comb begin
    state_d = state_q;
    miss_d = miss_q;
    shadow_d = shadow_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    d_d = d_q;
    fv_d = 1'b0;
    se_d = 1'b0;
    clr = 1'b0;
    load = 1'b0;
    en = 1'b0;
    if (din_valid) begin
      if (state_q == IDLE) begin
        if (sync) begin
          shadow_d[0] = din;
          load = 1'b1;
          state_d = RUN;
          miss_d = '0;
        end
      end else if (sync) begin
        shadow_d[0] = din;
        load = 1'b1;
        se_d = slot != SLOT_A;
        miss_d = slot == SLOT_A ? '0 : miss_q;
      end else if (slot == SLOT_A) begin
        miss_d = miss_q + 4'd1;
        if (miss_d == MISS_LIM) begin
          state_d = IDLE;
          clr = 1'b1;
        end else begin
          shadow_d[0] = din;
          en = 1'b1;
        end
      end else begin
        en = 1'b1;
        for (int i = 1; i < 3; i++) if (slot == 2'(i)) shadow_d[i] = din;
        if (slot == SLOT_D) begin
          a_d = shadow_q[0];
          b_d = shadow_q[1];
          c_d = shadow_q[2];
          d_d = din;
          fv_d = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      miss_q <= '0;
      shadow_q <= '{default: '0};
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      fv_q <= 1'b0;
      se_q <= 1'b0;
    end else begin
      state_q <= state_d;
      miss_q <= miss_d;
      shadow_q <= shadow_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      d_q <= d_d;
      fv_q <= fv_d;
      se_q <= se_d;
    end
  end
  assign A = a_q;
  assign B = b_q;
  assign C = c_q;
  assign D = d_q;
  assign frame_valid = fv_q;
  assign sync_err = se_q;
  assign locked = state_q == RUN;
endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: receiving end of the 4:1 `mux` path. Accepts a serial slot stream of W-bit beats with a frame-sync marker and steers each beat into one of four channel registers. Publishes all four channels together once per complete frame. Tracks frame alignment, flags misplaced sync, and drops lock after repeated missing syncs.

## Interface
Parameters:
- W, 1: beat and channel width in bits.
- MISS_MAX, 4: consecutive frame starts without `sync` before lock is dropped; range 1..15.

Ports:
- clk, input, 1: single clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- din, input, W: slot data beat.
- din_valid, input, 1: `din` carries a beat this cycle. No backpressure exists.
- sync, input, 1: qualified by `din_valid`; marks the current beat as slot 0.
- A, B, C, D, output, W each: channel registers for slots 0, 1, 2 and 3.
- frame_valid, output, 1: one-cycle pulse; A–D were updated on this edge.
- slot, output, 2: next slot expected, {S2,S1} order with S2 as MSB. Slot 0 selects A and slot 3 selects D.
- locked, output, 1: high in state RUN.
- sync_err, output, 1: one-cycle pulse when `sync` arrives in a nonzero slot.

## Operation
- Two states: IDLE (unlocked) and RUN.
- A beat is a cycle with `din_valid` = 1. Cycles without a beat change nothing except clearing the pulse outputs.
- In IDLE, beats without `sync` are discarded.
- In IDLE, a beat with `sync` does all of the following:
  - writes shadow[0];
  - sets `slot` to 1;
  - moves to RUN;
  - clears the miss counter.
- In RUN, a beat with `sync` = 0 writes shadow[slot], then `slot` becomes `slot` + 1 mod 4.
- In RUN, a beat with `sync` = 1 and `slot` = 0 is a normal beat and clears the miss counter.
- In RUN, a beat with `sync` = 1 and `slot` ≠ 0 is a resync:
  - pulses `sync_err`;
  - discards the partial frame, so A–D are not updated;
  - stores the beat as shadow[0] and sets `slot` to 1.
- In RUN, a beat with `slot` = 0 and `sync` = 0 increments the miss counter and is still accepted as slot 0.
  - If this increment makes the counter reach MISS_MAX, go to IDLE, set `slot` to 0 and discard the beat.
- Slot-3 beat accepted:
  - A, B and C load from shadow[0..2];
  - D loads directly from `din`;
  - `frame_valid` pulses.
- A–D hold their values between frames and while in IDLE.
- `rst` (any cycle, including mid-frame) sets:
  - state to IDLE;
  - `slot`, the miss counter and the shadows to 0;
  - A–D to 0;
  - `frame_valid`, `sync_err` and `locked` to 0.
- A partial frame is lost on reset.

## Timing
- All outputs are registered.
- A–D and `frame_valid` change on the same edge that samples the slot-3 beat, so latency is 1 clock from that beat.
- `frame_valid` and `sync_err` are exactly one cycle wide; they cannot both be 1 in the same cycle.
- Back-to-back beats are sustained at 1 per clock: a frame every 4 clocks, with `frame_valid` every 4th cycle.
- Idle gaps inside a frame are allowed; `slot` holds across them.
- `locked` rises on the edge that samples the acquiring sync beat and falls on the edge that samples the MISS_MAX-th unsynced frame start.
- `rst` takes priority over any simultaneous beat.

## Structure
- Package `tdm_pkg`:
  - state enum {IDLE, RUN};
  - slot localparams SLOT_A = 2'd0 through SLOT_D = 2'd3;
  - miss-counter width of 4 bits.
- One natural sub-module: `tdm_slot_ctr`, a 2-bit slot counter with a synchronous load-to-1 and clear, plus increment-on-enable.
- Shadow registers, miss counter and output registers live in the top level.

## Test plan
- Acquire and stream (W = 1):
  - Stimulus: after reset, beats 1,0,1,1 with `sync` on the first beat.
  - Response: `frame_valid` pulses once with A=1, B=0, C=1, D=1; `locked` = 1; `slot` returns to 0.
- Reset values:
  - Stimulus: hold `rst` for 2 cycles.
  - Response: A–D, `slot`, `locked`, `frame_valid` and `sync_err` are all 0.
- Gapped frame (W = 4):
  - Stimulus: beats 4'h3, 4'h5, 4'hA, 4'hC with 2 idle cycles between each.
  - Response: one `frame_valid` 1 clock after 4'hC; A–D = 3, 5, A, C.
- Misplaced sync:
  - Stimulus: in RUN, `sync` on the slot-2 beat, followed by 3 more beats.
  - Response: `sync_err` pulses; no `frame_valid` for the broken frame; the next frame is built from the sync beat plus the following 3 beats.
- Lock loss (MISS_MAX = 4):
  - Stimulus: send 4 consecutive frames without `sync`.
  - Response: `locked` drops at the 4th frame start; subsequent beats are ignored until a `sync` beat arrives.
- Mid-frame reset:
  - Stimulus: assert `rst` after 2 beats, then send a full synced frame.
  - Response: only the new frame appears on A–D; no stale shadow data.
